// File: rtl/branch_predictor_table.sv
// ============================================================================
// Module   : branch_predictor_table
// Brief    : Direction predictor table of saturating counters; 1-cycle lookup,
//            independent update port. Optional gshare indexing via BP_GSHARE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor_table #(
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int HIST_BITS  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_en,
  input  logic [31:0]           lookup_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [CTR_BITS-1:0]   pred_ctr,
  output logic [HIST_BITS-1:0]  pred_hist,
  input  logic                  update_en,
  input  logic [31:0]           update_pc,
  input  logic                  update_taken,
  input  logic [HIST_BITS-1:0]  update_hist
);

  localparam int                ENTRIES    = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] C_CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] C_CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};

  logic [CTR_BITS-1:0]   table_q [ENTRIES];
  logic                  pred_valid_q;
  logic [CTR_BITS-1:0]   pred_ctr_q;
  logic [HIST_BITS-1:0]  pred_hist_q;

  logic [INDEX_BITS-1:0] w_lu_base;
  logic [INDEX_BITS-1:0] w_up_base;
  logic [INDEX_BITS-1:0] w_lu_idx;
  logic [INDEX_BITS-1:0] w_up_idx;
  logic [HIST_BITS-1:0]  w_lu_hist;
  logic [CTR_BITS-1:0]   w_up_cur;
  logic [CTR_BITS-1:0]   w_up_next;
  logic                  w_unused;

  assign w_lu_base = lookup_pc[INDEX_BITS+1:2];
  assign w_up_base = update_pc[INDEX_BITS+1:2];

`ifdef BP_GSHARE_EN
  logic [HIST_BITS-1:0] hist_q;
  logic [HIST_BITS-1:0] hist_d;

  generate
    if (HIST_BITS == 1) begin : g_hist_one
      assign hist_d = update_taken;
    end else begin : g_hist_shift
      assign hist_d = {hist_q[HIST_BITS-2:0], update_taken};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
    end else if (update_en) begin
      hist_q <= hist_d;
    end
  end

  // Update side uses the history snapshot that travelled with the branch.
  assign w_lu_idx  = w_lu_base ^ INDEX_BITS'(hist_q);
  assign w_up_idx  = w_up_base ^ INDEX_BITS'(update_hist);
  assign w_lu_hist = hist_q;
  assign w_unused  = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0],
                       update_pc[31:INDEX_BITS+2], update_pc[1:0]};
`else
  assign w_lu_idx  = w_lu_base;
  assign w_up_idx  = w_up_base;
  assign w_lu_hist = '0;
  assign w_unused  = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0],
                       update_pc[31:INDEX_BITS+2], update_pc[1:0], update_hist};
`endif

  assign w_up_cur = table_q[w_up_idx];

  always_comb begin
    w_up_next = w_up_cur;
    if (update_taken) begin
      if (w_up_cur != C_CTR_MAX) w_up_next = w_up_cur + CTR_BITS'(1);
    end else begin
      if (w_up_cur != '0) w_up_next = w_up_cur - CTR_BITS'(1);
    end
  end

  // Lookup reads the registered array, so a same-index update is not bypassed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= C_CTR_INIT;
      pred_valid_q <= 1'b0;
      pred_ctr_q   <= '0;
      pred_hist_q  <= '0;
    end else begin
      pred_valid_q <= lookup_en;
      if (lookup_en) begin
        pred_ctr_q  <= table_q[w_lu_idx];
        pred_hist_q <= w_lu_hist;
      end
      if (update_en) table_q[w_up_idx] <= w_up_next;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_ctr   = pred_ctr_q;
  assign pred_taken = pred_ctr_q[CTR_BITS-1];
  assign pred_hist  = pred_hist_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_table.sv
// ============================================================================
// Module   : tb_branch_predictor_table
// Brief    : Scoreboard bench for branch_predictor_table (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor_table;

  logic        clk;
  logic        rst;
  logic        lookup_en;
  logic [31:0] lookup_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [1:0]  pred_ctr;
  logic [5:0]  pred_hist;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [5:0]  update_hist;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] ctr;
    logic [5:0] hist;
  } exp_t;

  exp_t exp_q[$];

  branch_predictor_table dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_en    (lookup_en),
    .lookup_pc    (lookup_pc),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .pred_ctr     (pred_ctr),
    .pred_hist    (pred_hist),
    .update_en    (update_en),
    .update_pc    (update_pc),
    .update_taken (update_taken),
    .update_hist  (update_hist)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_pred(input logic [1:0] ctr, input logic [5:0] hist);
    exp_t e;
    e.ctr  = ctr;
    e.hist = hist;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic le, input logic [31:0] lpc,
                      input logic ue, input logic [31:0] upc,
                      input logic ut, input logic [5:0] uh);
    lookup_en    = le;
    lookup_pc    = lpc;
    update_en    = ue;
    update_pc    = upc;
    update_taken = ut;
    update_hist  = uh;
    @(posedge clk);
    #1;
    lookup_en = 1'b0;
    update_en = 1'b0;
  endtask

  // Monitor: every valid prediction must match the oldest queued expectation.
  always @(negedge clk) begin
    if (pred_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got pred_valid=1 expected no prediction");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pred_ctr",   {30'd0, pred_ctr},  {30'd0, e.ctr});
        chk("pred_taken", {31'd0, pred_taken}, {31'd0, e.ctr[1]});
        chk("pred_hist",  {26'd0, pred_hist}, {26'd0, e.hist});
      end
    end
  end

  initial begin
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    step(1, 32'h100, 1, 32'h100, 1, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", {31'd0, pred_valid}, 32'd0);
    chk("reset_ctr",   {30'd0, pred_ctr},   32'd0);
    chk("reset_hist",  {26'd0, pred_hist},  32'd0);
    @(posedge clk);
    #1;

`ifdef BP_GSHARE_EN
    expect_pred(2'b01, 6'b000000);
    step(1, 32'h100, 1, 32'h300, 1, 6'b000000);   // pre-update history used
    step(0, 0,       1, 32'h300, 1, 6'b000000);
    step(0, 0,       1, 32'h300, 1, 6'b000000);   // history 000111, entry0=11
    expect_pred(2'b01, 6'b000111);
    step(1, 32'h100, 0, 0, 0, 0);                 // reads entry 7
    step(0, 0,       1, 32'h100, 1, 6'b000111);   // entry 7 -> 10, hist 001111
    expect_pred(2'b10, 6'b001111);
    step(1, 32'h20,  0, 0, 0, 0);                 // 8^15 = entry 7
    expect_pred(2'b11, 6'b001111);
    step(1, 32'h3C,  0, 0, 0, 0);                 // 15^15 = entry 0
    expect_pred(2'b01, 6'b001111);
    step(1, 32'h78,  1, 32'h300, 0, 6'b000000);   // entry 17; entry0 -> 10
    expect_pred(2'b10, 6'b011110);
    step(1, 32'h78,  0, 0, 0, 0);                 // 30^30 = entry 0
`else
    expect_pred(2'b01, 0);
    step(1, 32'h100, 0, 0, 0, 0);
    expect_pred(2'b01, 0);
    step(1, 32'h100, 1, 32'h100, 1, 0);           // no bypass, entry0 -> 10
    expect_pred(2'b10, 0);
    step(1, 32'h100, 1, 32'h100, 1, 0);           // entry0 -> 11
    expect_pred(2'b11, 0);
    step(1, 32'h200, 1, 32'h100, 1, 0);           // alias index 0, saturates
    expect_pred(2'b01, 0);
    step(1, 32'h104, 1, 32'h108, 0, 0);           // different indices
    expect_pred(2'b00, 0);
    step(1, 32'h108, 0, 0, 0, 0);
    expect_pred(2'b11, 0);
    step(1, 32'h100, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("idle_valid",    {31'd0, pred_valid}, 32'd0);
    chk("hold_ctr",      {30'd0, pred_ctr},   32'd3);
    chk("hold_taken",    {31'd0, pred_taken}, 32'd1);
    @(posedge clk);
    #1;
    expect_pred(2'b11, 0);
    step(1, 32'h100, 1, 32'h100, 0, 0);           // entry0 -> 10
    expect_pred(2'b10, 0);
    step(1, 32'h100, 0, 0, 0, 0);
    step(0, 0, 1, 32'h100, 0, 0);                 // 01
    step(0, 0, 1, 32'h100, 0, 0);                 // 00
    step(0, 0, 1, 32'h100, 0, 0);                 // stays 00
    expect_pred(2'b00, 0);
    step(1, 32'h100, 0, 0, 0, 0);
    expect_pred(2'b00, 0);
    step(1, 32'hFFFF_FF03, 0, 0, 0, 0);           // upper and low bits ignored
    expect_pred(2'b01, 0);
    step(1, 32'h3FC, 0, 0, 0, 0);                 // top entry untouched
    step(0, 0, 1, 32'h100, 1, 0);
    step(0, 0, 1, 32'h100, 1, 0);
    step(0, 0, 1, 32'h100, 1, 0);                 // entry0 back to 11
    expect_pred(2'b11, 0);
    step(1, 32'h100, 0, 0, 0, 0);
`endif

    rst = 1'b1;
    step(1, 32'h100, 1, 32'h104, 1, 0);           // rst beats lookup and update
    rst = 1'b0;
    @(negedge clk);
    chk("rst_lookup_valid", {31'd0, pred_valid}, 32'd0);
    @(posedge clk);
    #1;
    expect_pred(2'b01, 0);
    step(1, 32'h100, 0, 0, 0, 0);
    expect_pred(2'b01, 0);
    step(1, 32'h104, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
